// File: rtl/prg_seq_if.sv
// Bus bundle between the program sequencer, its program ROM and the instruction decoder.
// i_* / o_* prefixes are as seen from the sequencer (slave modport).
interface prg_seq_if;
  logic       i_run;
  logic       i_step;
  logic [7:0] i_rom_data;
  logic       i_rom_ack;
  logic       i_prg_cnt_ld;
  logic       o_rom_req;
  logic [3:0] o_rom_addr;
  logic [7:0] o_mc_code;
  logic       o_exec_en;
  logic [3:0] o_pc;
  logic       o_busy;
  logic       o_err;

  modport slave (
    input  i_run, i_step, i_rom_data, i_rom_ack, i_prg_cnt_ld,
    output o_rom_req, o_rom_addr, o_mc_code, o_exec_en, o_pc, o_busy, o_err
  );

  modport master (
    output i_run, i_step, i_rom_data, i_rom_ack, i_prg_cnt_ld,
    input  o_rom_req, o_rom_addr, o_mc_code, o_exec_en, o_pc, o_busy, o_err
  );
endinterface

// File: rtl/prg_seq.sv
// Program sequencer: fetch / decode / execute loop over a 16-word program ROM,
// with single-step, free-run and a sticky ROM-timeout error.
//
//   state    | meaning
//   S_IDLE   | waiting for RUN or STEP (blocked while ERR is set)
//   S_FETCH  | ROM_REQ high until ROM_ACK, timeout down-counter running
//   S_DECODE | one cycle, MC_CODE stable for the decoder
//   S_EXEC   | one cycle EXEC_EN strobe, PC updated at its closing edge
module prg_seq #(
  parameter logic [3:0] P_TMO = 4'hF
) (
  input logic    clk,
  input logic    rst_n,
  prg_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_EXEC   = 2'd3
  } state_t;

  localparam logic [3:0] LP_TMO_LD = P_TMO - 4'd1;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_arm;
  logic [3:0] r_pc;
  logic [3:0] r_tmo;
  logic [7:0] r_mc_code;
  logic       r_err;
  logic       w_fetch_entry;
  logic       w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_arm && !r_err && (bus.i_run || bus.i_step)) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (bus.i_rom_ack)      w_state_nxt = S_DECODE;
        else if (r_tmo == 4'd0) w_state_nxt = S_IDLE;
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (bus.i_run) w_state_nxt = S_FETCH;
        else           w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fetch_entry = (w_state_nxt == S_FETCH) && (r_state != S_FETCH);
  assign w_timeout     = (r_state == S_FETCH) && !bus.i_rom_ack && (r_tmo == 4'd0);

  // r_arm delays the first fetch by one edge so reset release is seen synchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_arm     <= 1'b0;
      r_pc      <= 4'h0;
      r_tmo     <= 4'h0;
      r_mc_code <= 8'h00;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_arm   <= 1'b1;
      if (w_fetch_entry) begin
        r_tmo <= LP_TMO_LD;
      end else if ((r_state == S_FETCH) && (r_tmo != 4'd0)) begin
        r_tmo <= r_tmo - 4'd1;
      end
      if ((r_state == S_FETCH) && bus.i_rom_ack) begin
        r_mc_code <= bus.i_rom_data;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state == S_EXEC) begin
        r_pc <= bus.i_prg_cnt_ld ? r_mc_code[3:0] : r_pc + 4'd1;
      end
    end
  end

  assign bus.o_rom_req  = (r_state == S_FETCH);
  assign bus.o_exec_en  = (r_state == S_EXEC);
  assign bus.o_busy     = (r_state != S_IDLE);
  assign bus.o_rom_addr = r_pc;
  assign bus.o_pc       = r_pc;
  assign bus.o_mc_code  = r_mc_code;
  assign bus.o_err      = r_err;

endmodule

// File: doc/prg_seq.md
PRG_SEQ -- requirements
Module: prg_seq

Interface
REQ-001 SHALL have parameter P_TMO, default 4'hF: maximum FETCH wait cycles before a ROM timeout.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port RUN, input, 1 bit: level; free-run instructions while high.
REQ-005 SHALL have port STEP, input, 1 bit: execute exactly one instruction when sampled high in IDLE.
REQ-006 SHALL have port ROM_DATA, input, 8 bits: program memory read data.
REQ-007 SHALL have port ROM_ACK, input, 1 bit: ROM_DATA valid this cycle.
REQ-008 SHALL have port PRG_CNT_LD, input, 1 bit: jump request from the decoder, sampled in EXEC.
REQ-009 SHALL have port ROM_REQ, output, 1 bit: program memory read request.
REQ-010 SHALL have port ROM_ADDR, output, 4 bits: program memory address; always equals PC.
REQ-011 SHALL have port MC_CODE, output, 8 bits: instruction register, driven to the decoder.
REQ-012 SHALL have port EXEC_EN, output, 1 bit: one-cycle strobe that qualifies the decoder register/memory load pulses.
REQ-013 SHALL have port PC, output, 4 bits: program counter.
REQ-014 SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port ERR, output, 1 bit: sticky ROM-timeout flag.

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE and EXEC, one-hot or encoded.
REQ-017 IDLE SHALL go to FETCH on the next edge when RUN=1 or STEP=1 and ERR=0; otherwise it SHALL stay in IDLE.
REQ-018 In FETCH, ROM_REQ SHALL be 1 every cycle until ROM_ACK=1 is sampled.
REQ-019 On the FETCH edge where ROM_ACK=1, the block SHALL load MC_CODE<=ROM_DATA and go to DECODE.
REQ-020 FETCH SHALL count wait cycles; if P_TMO cycles elapse without ROM_ACK, the block SHALL set ERR=1, go to IDLE, and leave MC_CODE and PC unchanged.
REQ-021 DECODE SHALL last exactly 1 cycle with MC_CODE stable, then go to EXEC.
REQ-022 EXEC SHALL last exactly 1 cycle with EXEC_EN=1; EXEC_EN SHALL be 0 in all other states.
REQ-023 At the EXEC edge, PC SHALL take MC_CODE[3:0] if PRG_CNT_LD=1, else PC+1 modulo 16 (4'hF wraps to 4'h0; no carry out).
REQ-024 After EXEC, the next state SHALL be FETCH if RUN=1, else IDLE.
REQ-025 A STEP-initiated instruction SHALL return to IDLE unless RUN=1 at EXEC.
REQ-026 With zero-wait ROM (ROM_ACK in the first FETCH cycle), throughput SHALL be 1 instruction per 3 cycles.
REQ-027 STEP SHALL be ignored outside IDLE; it SHALL NOT be queued.
REQ-028 RUN falling mid-instruction SHALL let the current instruction complete through EXEC, then go to IDLE.
REQ-029 RUN=1 and STEP=1 together in IDLE SHALL be treated as RUN.
REQ-030 ROM_ACK outside FETCH SHALL be ignored.
REQ-031 While ERR=1, IDLE SHALL ignore RUN and STEP; ERR SHALL be cleared only by reset.
REQ-032 A self-jump (PRG_CNT_LD=1 with MC_CODE[3:0]=PC) SHALL be legal and SHALL loop.
REQ-033 All outputs SHALL be registered, except that ROM_REQ, EXEC_EN and BUSY may be decoded directly from state.

Reset
REQ-034 While RST_N=0, the block SHALL asynchronously force state=IDLE, PC=4'h0, MC_CODE=8'h00, ERR=0, timeout count=0, ROM_REQ=0, EXEC_EN=0 and BUSY=0.
REQ-035 Reset asserted mid-FETCH or mid-EXEC SHALL abort the instruction, and no EXEC_EN pulse SHALL follow.
REQ-036 Reset release SHALL be taken synchronously; the first FETCH SHALL occur no earlier than the second edge after release with RUN=1.

Verification
REQ-037 Directed test: reset, then RUN=1 with ROM returning 8'h05, 8'hA1, ... and zero-wait ROM_ACK -> ROM_ADDR 0,1,2 on cycles 1,4,7; EXEC_EN pulses every 3rd cycle; PC increments.
REQ-038 Directed test: ROM word 8'hD7 at PC=3 with PRG_CNT_LD=1 in EXEC -> PC=7 and the next ROM_ADDR=7.
REQ-039 Directed test: PC=4'hF with a non-jump instruction -> next PC=4'h0, ROM_ADDR=0, ERR=0.
REQ-040 Directed test: RUN=0, one-cycle STEP pulse -> exactly one EXEC_EN pulse, PC+1, BUSY returns to 0; a STEP given during BUSY causes no second instruction.
REQ-041 Directed test: ROM_ACK held low for 15 cycles in FETCH -> ERR=1, IDLE, PC unchanged; further RUN/STEP produce no ROM_REQ until RST_N pulses low.
REQ-042 Directed test: RST_N low during EXEC cycle -> EXEC_EN=0 immediately, PC=0, MC_CODE=8'h00, state IDLE.
